// File: rtl/tdm_demux4_pkg.sv
// Shared constants and types for the four-channel TDM demultiplexer.
package tdm_demux4_pkg;

  localparam int unsigned NSLOT  = 4;
  localparam int unsigned SLOT_W = 2;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux4_slot_ctr.sv
// Expected-slot counter: wraps modulo NSLOT, can be forced to slot 1 or cleared.
module tdm_slot_ctr
  import tdm_demux4_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot
);

  // Priority: clear, then load-to-1, then increment (natural 2-bit wrap).
  always_ff @(posedge clk) begin
    if (clr) begin
      slot <= '0;
    end else if (load) begin
      slot <= SLOT_W'(1);
    end else if (inc) begin
      slot <= slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: rebuilds d0..d3 from a rotating slot stream
// and presents each complete frame as one registered parallel word set.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         frame_start,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1,
  output logic [W-1:0] q2,
  output logic [W-1:0] q3,
  output logic         q_valid,
  output logic         s1,
  output logic         s0,
  output logic         locked,
  output logic         frame_err
);

  state_t            state, state_n;
  logic [SLOT_W-1:0] slot;
  logic              slot_inc, slot_load;
  logic [W-1:0]      shadow   [NSLOT-1];
  logic [W-1:0]      shadow_n [NSLOT-1];
  logic [W-1:0]      q_r      [NSLOT];
  logic [W-1:0]      q_n      [NSLOT];
  logic              q_valid_n, frame_err_n;

  tdm_slot_ctr u_slot_ctr (
    .clk  (clk),
    .clr  (rst),
    .load (slot_load),
    .inc  (slot_inc),
    .slot (slot)
  );

  // Next-state, shadow capture and frame publish.
  always_comb begin
    state_n     = state;
    slot_inc    = 1'b0;
    slot_load   = 1'b0;
    shadow_n    = shadow;
    q_n         = q_r;
    q_valid_n   = 1'b0;
    frame_err_n = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (frame_start) begin
            state_n     = LOCK;
            slot_load   = 1'b1;
            shadow_n[0] = din;
          end
        end
        LOCK: begin
          if (frame_start && (slot != '0)) begin
            // Misplaced marker: drop the partial frame and realign on this beat.
            frame_err_n = 1'b1;
            slot_load   = 1'b1;
            shadow_n[0] = din;
          end else begin
            slot_inc = 1'b1;
            case (slot)
              SLOT_W'(0): shadow_n[0] = din;
              SLOT_W'(1): shadow_n[1] = din;
              SLOT_W'(2): shadow_n[2] = din;
              default: begin
                q_n[0]    = shadow[0];
                q_n[1]    = shadow[1];
                q_n[2]    = shadow[2];
                q_n[3]    = din;
                q_valid_n = 1'b1;
              end
            endcase
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      locked    <= 1'b0;
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < NSLOT - 1; i++) shadow[i] <= '0;
      for (int i = 0; i < NSLOT; i++) q_r[i] <= '0;
    end else begin
      state     <= state_n;
      locked    <= (state_n == LOCK);
      q_valid   <= q_valid_n;
      frame_err <= frame_err_n;
      shadow    <= shadow_n;
      q_r       <= q_n;
    end
  end

  assign q0 = q_r[0];
  assign q1 = q_r[1];
  assign q2 = q_r[2];
  assign q3 = q_r[3];
  assign s1 = slot[1];
  assign s0 = slot[0];

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: frame-level reference model compared every cycle,
// plus hand-computed checkpoints from the directed scenarios.
module tb_tdm_demux4;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic [W-1:0] q0, q1, q2, q3;
  logic         q_valid, s1, s0, locked, frame_err;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;
  bit cnt_en  = 1'b0;
  int qv_cnt  = 0;
  int fe_cnt  = 0;

  // Reference model: where we are in the frame, what has been collected,
  // and what the last completed frame was.
  bit           m_lock;
  int           m_slot;
  logic [W-1:0] m_buf [4];
  logic [W-1:0] m_q   [4];
  bit           m_qv, m_fe;

  tdm_demux4 #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .q0          (q0),
    .q1          (q1),
    .q2          (q2),
    .q3          (q3),
    .q_valid     (q_valid),
    .s1          (s1),
    .s0          (s0),
    .locked      (locked),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m_qv = 1'b0;
    m_fe = 1'b0;
    if (rst) begin
      m_lock = 1'b0;
      m_slot = 0;
      for (int i = 0; i < 4; i++) begin
        m_buf[i] = '0;
        m_q[i]   = '0;
      end
    end else if (din_valid) begin
      if (!m_lock) begin
        if (frame_start) begin
          m_lock   = 1'b1;
          m_buf[0] = din;
          m_slot   = 1;
        end
      end else if (frame_start && m_slot != 0) begin
        m_fe     = 1'b1;
        m_buf[0] = din;
        m_slot   = 1;
      end else begin
        m_buf[m_slot] = din;
        if (m_slot == 3) begin
          m_q  = m_buf;
          m_qv = 1'b1;
        end
        m_slot = (m_slot + 1) % 4;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("q0", 32'(q0), 32'(m_q[0]));
      chk("q1", 32'(q1), 32'(m_q[1]));
      chk("q2", 32'(q2), 32'(m_q[2]));
      chk("q3", 32'(q3), 32'(m_q[3]));
      chk("q_valid", 32'(q_valid), 32'(m_qv));
      chk("slot", 32'({s1, s0}), 32'(m_slot));
      chk("locked", 32'(locked), 32'(m_lock));
      chk("frame_err", 32'(frame_err), 32'(m_fe));
    end
    if (cnt_en) begin
      qv_cnt += int'(q_valid);
      fe_cnt += int'(frame_err);
    end
  end

  task automatic cyc(input logic r, input logic v, input logic fs, input logic [W-1:0] d);
    @(negedge clk);
    rst = r; din_valid = v; frame_start = fs; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_q(input string name, input logic [15:0] exp);
    chk(name, 32'({q0, q1, q2, q3}), 32'(exp));
  endtask

  initial begin
    // Reset then frame A,B,C,D
    cyc(1, 0, 0, 0);
    chk_en = 1'b1;
    cyc(1, 0, 0, 0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk_q("rst_q", 16'h0000);
    cyc(0, 1, 1, 4'hA);
    chk("t1_locked", 32'(locked), 32'd1);
    cyc(0, 1, 0, 4'hB);
    cyc(0, 1, 0, 4'hC);
    chk("t1_qv_early", 32'(q_valid), 32'd0);
    cyc(0, 1, 0, 4'hD);
    chk_q("t1_q", 16'hABCD);
    chk("t1_qv", 32'(q_valid), 32'd1);
    cyc(0, 0, 0, 0);
    chk("t1_qv_pulse", 32'(q_valid), 32'd0);

    // HUNT discards beats without frame_start
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 4'h1);
    cyc(0, 1, 0, 4'h2);
    chk("t2_hunt", 32'(locked), 32'd0);
    cyc(0, 1, 1, 4'h5);
    cyc(0, 1, 0, 4'h6);
    cyc(0, 1, 0, 4'h7);
    cyc(0, 1, 0, 4'h8);
    chk_q("t2_q", 16'h5678);

    // Gaps of 3 idle cycles between beats
    cyc(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, (i == 1), 4'(i));
      for (int g = 0; g < 3; g++) cyc(0, 0, 1, 4'hF);
      if (i == 1) chk("t3_gap_slot", 32'({s1, s0}), 32'd1);
    end
    chk_q("t3_q", 16'h1234);

    // Misplaced frame_start on the slot-2 beat
    cyc(0, 1, 0, 4'h9);
    cyc(0, 1, 0, 4'hA);
    cyc(0, 1, 1, 4'hB);
    chk("t4_err", 32'(frame_err), 32'd1);
    chk_q("t4_hold", 16'h1234);
    cyc(0, 1, 0, 4'hC);
    chk("t4_err_pulse", 32'(frame_err), 32'd0);
    cyc(0, 1, 0, 4'hD);
    chk_q("t4_hold2", 16'h1234);
    cyc(0, 1, 0, 4'hE);
    chk_q("t4_q", 16'hBCDE);

    // Reset in the middle of a frame
    cyc(0, 1, 1, 4'h1);
    cyc(0, 1, 0, 4'h2);
    cyc(1, 1, 0, 4'h3);
    chk("t5_locked", 32'(locked), 32'd0);
    chk_q("t5_q", 16'h0000);
    cyc(0, 1, 0, 4'h3);
    cyc(0, 1, 0, 4'h4);
    chk("t5_slot", 32'({s1, s0}), 32'd0);

    // Three back-to-back frames
    cnt_en = 1'b1;
    for (int i = 0; i < 12; i++) cyc(0, 1, (i % 4 == 0), 4'(i + 3));
    cyc(0, 0, 0, 0);
    cnt_en = 1'b0;
    chk("t6_qv_cnt", 32'(qv_cnt), 32'd3);
    chk("t6_fe_cnt", 32'(fe_cnt), 32'd0);
    chk_q("t6_q", 16'hBCDE);

    cyc(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer. It receives one serial word stream in which consecutive valid beats carry channels 0, 1, 2, 3 in rotation, with a frame marker on the channel-0 beat. It rebuilds the four channel values and presents them as one registered parallel frame. It is the receive-side counterpart of the 4-to-1 channel multiplexer and is used wherever a multiplexed link must be split back into d0..d3.

## Interface
Parameters:
- W, 1, width of each channel word

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- din  input  W  multiplexed channel word for the current slot
- din_valid  input  1  din carries a slot beat this cycle
- frame_start  input  1  qualifies the current beat as slot 0; ignored when din_valid=0
- q0  output  W  channel 0 of last complete frame
- q1  output  W  channel 1 of last complete frame
- q2  output  W  channel 2 of last complete frame
- q3  output  W  channel 3 of last complete frame
- q_valid  output  1  one-cycle pulse: q0..q3 updated this cycle
- s1  output  1  expected slot index, MSB
- s0  output  1  expected slot index, LSB
- locked  output  1  aligned to frame boundary
- frame_err  output  1  one-cycle pulse: misplaced frame_start detected

## Operation
- States:
  - HUNT (reset state, locked=0): all beats are discarded.
  - LOCK (locked=1).
- HUNT to LOCK: a beat with din_valid=1 and frame_start=1.
  - din is stored in shadow[0] and {s1,s0} becomes 1.
- LOCK, din_valid=1, frame_start=0:
  - shadow[{s1,s0}] <= din.
  - {s1,s0} increments modulo 4 (3 wraps to 0).
- LOCK beat at slot 3:
  - q0..q2 <= shadow[0..2] and q3 <= din, all on the same edge.
  - q_valid=1 for that cycle.
  - {s1,s0} wraps to 0.
- LOCK, frame_start=1 at slot 0: legal; handled as a normal slot-0 beat.
- LOCK, frame_start=1 at slot 1..3 (misalignment):
  - frame_err pulses for one cycle.
  - The partial frame is discarded and q0..q3 are unchanged.
  - The beat is taken as a new slot 0: shadow[0] <= din and {s1,s0} <= 1.
  - State stays LOCK.
- din_valid=0: no state change (gaps of any length are allowed between beats).
- q0..q3 hold their value between frames. Shadow contents are never visible on outputs.

## Timing
- Reset values (registered, in effect the cycle after rst is sampled high):
  - q0..q3 = 0, q_valid = 0, {s1,s0} = 0, locked = 0, frame_err = 0.
  - state = HUNT, shadow = 0.
- rst has priority over every input, including during a partly assembled frame. That frame is lost, and locking again requires a new frame_start.
- Latency: q0..q3 and q_valid update on the clock edge that samples the slot-3 beat, so they are visible in the cycle after that beat is presented.
- frame_err is registered and asserts in the cycle after the offending beat.
- Throughput: one frame per 4 valid beats. Back-to-back frames give q_valid every 4th cycle.
- {s1,s0} and locked are registered and always show the slot expected for the next beat.

## Structure
- Shared package:
  - NSLOT = 4 and the slot width constant (2).
  - State enum HUNT/LOCK.
- One sub-module, tdm_slot_ctr: a 2-bit wrap counter with inc, load-to-1 and clear inputs, driving s1/s0. Everything else is flat.
- Shadow: three W-bit registers. Slot 3 is never stored; it goes directly to q3.

## Test plan
- Reset then frame, W=4:
  - Stimulus: rst for 2 cycles, then valid beats 0xA(fs=1), 0xB, 0xC, 0xD.
  - Response: one cycle after 0xD, q0..q3 = A,B,C,D and q_valid=1 for exactly 1 cycle; locked=1 from after the first beat.
- HUNT discard:
  - Stimulus: beats 0x1, 0x2 with fs=0 after reset, then the frame 5,6,7,8 with fs on 5.
  - Response: locked=0 until beat 5; q = 5,6,7,8; no q_valid before that.
- Gaps:
  - Stimulus: frame 1,2,3,4 with din_valid=0 for 3 cycles between each beat.
  - Response: q = 1,2,3,4 and q_valid pulses once; {s1,s0} holds during gaps.
- Misalignment:
  - Stimulus: after a locked frame (q = 1,2,3,4), send 9, A, then fs=1 on B, then C, D, E.
  - Response: frame_err pulses once after B; q stays 1,2,3,4 until E; then q = B,C,D,E.
- Reset mid-frame:
  - Stimulus: rst asserted after 2 beats of a frame.
  - Response: all outputs 0, locked=0; subsequent beats without fs are ignored.
- Back-to-back:
  - Stimulus: 3 continuous frames with fs every 4th beat.
  - Response: q_valid on every 4th cycle and frame_err never asserts.
